median_window_feeder: RTL and testbench

Upstream stage of the MEDIAN filter. It accepts a raster pixel stream, keeps the two previous lines in line buffers, and forms each 3x3 neighbourhood. It shifts the 9 window pixels serially into MEDIAN (DI/DSI), waits for DSO, captures DO as the filtered pixel, and clears MEDIAN before the next window.
It outputs an (IMG_W-2) x (IMG_H-2) image. Border pixels produce no result.

---
 rtl/median_pkg.sv | 14 +
 rtl/median_line_buffer.sv | 32 +++
 rtl/median_window_feeder.sv | 162 ++++++++++++++++
 tb/tb_median_window_feeder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared definitions for median_window_feeder: FSM encoding, window size,
// watchdog limit and counter width helper.
package median_pkg;

    typedef enum logic [2:0] {IDLE, SEND, WAIT, CAPT, CLR} fsm_t;

    localparam int WIN_SIZE   = 9;
    localparam int WDOG_LIMIT = 255;

    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/median_line_buffer.sv
// Two-line pixel history for the 3x3 window: combinational read of both
// previous lines at the current column, shift-down write on accept.
module median_line_buffer
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int AW    = cntWidth(IMG_W)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_pix,
    output logic [WIDTH-1:0] o_lb1,
    output logic [WIDTH-1:0] o_lb0
);

    logic [WIDTH-1:0] r_lb0 [IMG_W];
    logic [WIDTH-1:0] r_lb1 [IMG_W];

    assign o_lb0 = r_lb0[i_addr];
    assign o_lb1 = r_lb1[i_addr];

    // Contents are deliberately unreset; row gating keeps stale data out of results.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_lb1[i_addr] <= r_lb0[i_addr];
            r_lb0[i_addr] <= i_pix;
        end
    end

endmodule

// File: rtl/median_window_feeder.sv
// Builds 3x3 windows from a raster stream and feeds them serially to MEDIAN.
// Optional watchdog on the MEDIAN result wait: define MEDFEED_WDOG_EN.
module median_window_feeder
    import median_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] PIX_IN,
    input  logic             PIX_VALID,
    input  logic             SOF,
    output logic             PIX_READY,
    output logic [WIDTH-1:0] DI,
    output logic             DSI,
    output logic             MED_nRST,
    input  logic [WIDTH-1:0] MED_DO,
    input  logic             MED_DSO,
    output logic [WIDTH-1:0] RES,
    output logic             RES_VALID,
    output logic             ERR
);

    localparam int CW = cntWidth(IMG_W);
    localparam int RW = cntWidth(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [3:0]    IDX_LAST = 4'(WIN_SIZE);

    fsm_t             r_state, w_next;
    logic [CW-1:0]    r_col, w_col;
    logic [RW-1:0]    r_row, w_row;
    logic             w_accept, w_trig, w_timeout;
    logic [WIDTH-1:0] w_lb1, w_lb0;
    logic [WIDTH-1:0] r_win    [WIN_SIZE];
    logic [WIDTH-1:0] w_newWin [WIN_SIZE];
    logic [3:0]       r_idx;
    logic             r_clrN;

    assign PIX_READY = (r_state == IDLE);
    assign w_accept  = PIX_VALID && PIX_READY;
    assign w_col     = SOF ? '0 : r_col;
    assign w_row     = SOF ? '0 : r_row;
    assign w_trig    = w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign MED_nRST  = nRST & r_clrN;

    median_line_buffer #(.WIDTH(WIDTH), .IMG_W(IMG_W), .AW(CW)) u_lineBuf (
        .i_clk  (CLK),
        .i_we   (w_accept),
        .i_addr (w_col),
        .i_pix  (PIX_IN),
        .o_lb1  (w_lb1),
        .o_lb0  (w_lb0)
    );

    // Window is row-major, index 0 = oldest line / oldest column.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_newWin[3*r]     = r_win[3*r + 1];
            w_newWin[3*r + 1] = r_win[3*r + 2];
        end
        w_newWin[2] = w_lb1;
        w_newWin[5] = w_lb0;
        w_newWin[8] = PIX_IN;
    end

`ifdef MEDFEED_WDOG_EN
    logic [7:0] r_wdog;
    logic       r_err;

    assign w_timeout = (r_state == WAIT) && !MED_DSO && (r_wdog == 8'(WDOG_LIMIT - 1));
    assign ERR       = r_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state != WAIT)
                r_wdog <= '0;
            else if (!MED_DSO)
                r_wdog <= r_wdog + 8'd1;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign ERR       = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_trig) w_next = SEND;
            SEND:    if (r_idx == IDX_LAST) w_next = WAIT;
            WAIT: begin
                if (MED_DSO)
                    w_next = CAPT;
                else if (w_timeout)
                    w_next = CLR;
            end
            CAPT:    w_next = CLR;
            CLR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // clr_n is low exactly while in CLR, whether reached by capture or timeout.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_col     <= '0;
            r_row     <= '0;
            DI        <= '0;
            DSI       <= 1'b0;
            r_idx     <= '0;
            r_clrN    <= 1'b1;
            RES       <= '0;
            RES_VALID <= 1'b0;
            for (int i = 0; i < WIN_SIZE; i++)
                r_win[i] <= '0;
        end else begin
            r_clrN    <= (w_next != CLR);
            RES_VALID <= (r_state == CAPT);
            if (r_state == CAPT)
                RES <= MED_DO;
            if (w_accept) begin
                for (int i = 0; i < WIN_SIZE; i++)
                    r_win[i] <= w_newWin[i];
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
            if (w_trig) begin
                DI    <= w_newWin[0];
                DSI   <= 1'b1;
                r_idx <= 4'd1;
            end else if (r_state == SEND) begin
                if (r_idx == IDX_LAST) begin
                    DSI <= 1'b0;
                end else begin
                    DI    <= r_win[r_idx];
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder on a 4x4 frame with a behavioural
// MEDIAN; watchdog section is built only when MEDFEED_WDOG_EN is defined.
module tb_median_window_feeder;

    logic       clk = 1'b0;
    logic       nRst;
    logic [7:0] pixIn;
    logic       pixValid;
    logic       sof;
    logic       pixReady;
    logic [7:0] di;
    logic       dsi;
    logic       medNRst;
    logic [7:0] medDo;
    logic       medDso;
    logic [7:0] res;
    logic       resValid;
    logic       err;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    median_window_feeder #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
        .CLK       (clk),
        .nRST      (nRst),
        .PIX_IN    (pixIn),
        .PIX_VALID (pixValid),
        .SOF       (sof),
        .PIX_READY (pixReady),
        .DI        (di),
        .DSI       (dsi),
        .MED_nRST  (medNRst),
        .MED_DO    (medDo),
        .MED_DSO   (medDso),
        .RES       (res),
        .RES_VALID (resValid),
        .ERR       (err)
    );

    // Behavioural MEDIAN: collect 9 serial samples, then raise a sticky result.
    logic [7:0] medBuf [9];
    int         medCnt;
    logic       medDsoReg;
    logic [7:0] medDoReg;
    logic       tieDsoLow = 1'b0;

    function automatic logic [7:0] median9(input logic [7:0] v [9]);
        logic [7:0] t [9];
        logic [7:0] s;
        for (int i = 0; i < 9; i++) t[i] = v[i];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (t[j] > t[j+1]) begin
                    s = t[j]; t[j] = t[j+1]; t[j+1] = s;
                end
        return t[4];
    endfunction

    always @(posedge clk or negedge medNRst) begin
        if (!medNRst) begin
            medCnt    <= 0;
            medDsoReg <= 1'b0;
            medDoReg  <= '0;
        end else if (medCnt < 9) begin
            if (dsi) begin
                medBuf[medCnt] <= di;
                medCnt         <= medCnt + 1;
            end
        end else if (!medDsoReg) begin
            medDsoReg <= 1'b1;
            medDoReg  <= median9(medBuf);
        end
    end

    assign medDso = medDsoReg & ~tieDsoLow;
    assign medDo  = medDoReg;

    // Monitor on the falling edge, away from the active edge.
    logic [7:0] resQ [$];
    logic [7:0] diQ  [$];
    int         dsiRunQ [$];
    int         stallQ  [$];
    int dsiRun = 0, stallRun = 0, clrLow = 0, acceptCnt = 0;
    bit firstDone = 0;

    always @(negedge clk) begin
        if (resValid) resQ.push_back(res);
        if (pixValid && pixReady) acceptCnt++;
        if (nRst && !medNRst) clrLow++;
        if (dsi) begin
            dsiRun++;
            if (!firstDone) diQ.push_back(di);
        end else if (dsiRun != 0) begin
            dsiRunQ.push_back(dsiRun);
            dsiRun    = 0;
            firstDone = 1;
        end
        if (nRst && !pixReady) stallRun++;
        else if (stallRun != 0) begin
            stallQ.push_back(stallRun);
            stallRun = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        resQ.delete(); diQ.delete(); dsiRunQ.delete(); stallQ.delete();
        dsiRun = 0; stallRun = 0; clrLow = 0; acceptCnt = 0; firstDone = 0;
    endtask

    // Present one pixel with valid held, wait for its accepting edge.
    task automatic applyStimulus(input logic [7:0] pix, input logic sofBit);
        int n;
        pixIn = pix; sof = sofBit; pixValid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!pixReady && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) checkOutput("acceptTimeout", 32'(pixReady), 1);
        @(posedge clk); #1;
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int n;
        n = 0;
        while (!pixReady && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(pixReady), 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] resAt(input int i);
        return (i < resQ.size()) ? 32'(resQ[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] stallAt(input int i);
        return (i < stallQ.size()) ? 32'(stallQ[i]) : 32'hFFFF_FFFF;
    endfunction

    int expDi [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        nRst = 1'b0; pixIn = '0; pixValid = 1'b0; sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstReady", 32'(pixReady), 1);
        checkOutput("rstDsi", 32'(dsi), 0);
        checkOutput("rstDi", 32'(di), 0);
        checkOutput("rstResValid", 32'(resValid), 0);
        checkOutput("rstRes", 32'(res), 0);
        checkOutput("rstMedNRst", 32'(medNRst), 0);
        checkOutput("rstErr", 32'(err), 0);
        nRst = 1'b1;
        @(posedge clk); #1;
        checkOutput("relReady", 32'(pixReady), 1);
        checkOutput("relMedNRst", 32'(medNRst), 1);

        // Basic 4x4 frame, pixel = 16*row + col, valid held high throughout.
        clearLogs();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                applyStimulus(8'(16*r + c), (r == 0 && c == 0));
        pixValid = 1'b0; sof = 1'b0;
        waitIdle("basicIdle", 100);
        checkOutput("basicResCount", resQ.size(), 4);
        checkOutput("basicRes0", resAt(0), 17);
        checkOutput("basicRes1", resAt(1), 18);
        checkOutput("basicRes2", resAt(2), 33);
        checkOutput("basicRes3", resAt(3), 34);
        checkOutput("basicAccepts", acceptCnt, 16);
        checkOutput("basicClrCycles", clrLow, 4);
        checkOutput("diCount", diQ.size(), 9);
        for (int i = 0; i < 9; i++)
            checkOutput($sformatf("di%0d", i), (i < diQ.size()) ? 32'(diQ[i]) : 32'hFFFF_FFFF, expDi[i]);
        checkOutput("dsiRunCount", dsiRunQ.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("dsiRun%0d", i), (i < dsiRunQ.size()) ? 32'(dsiRunQ[i]) : 32'hFFFF_FFFF, 9);
        // SEND 9 + WAIT 2 + CAPT 1 + CLR 1 with this MEDIAN model.
        checkOutput("stallCount", stallQ.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("stall%0d", i), stallAt(i), 13);

        // SOF at old pixel (3,1) restarts counters.
        clearLogs();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                applyStimulus(8'(16*r + c), (r == 0 && c == 0));
        applyStimulus(8'd48, 1'b0);
        applyStimulus(8'd100, 1'b1);
        for (int k = 1; k < 8; k++)
            applyStimulus(8'(100 + 16*(k/4) + (k%4)), 1'b0);
        pixValid = 1'b0;
        waitIdle("sofIdleA", 100);
        checkOutput("sofNoEarlyRes", resQ.size(), 2);
        for (int c = 0; c < 4; c++)
            applyStimulus(8'(132 + c), 1'b0);
        pixValid = 1'b0;
        waitIdle("sofIdleB", 100);
        checkOutput("sofResCount", resQ.size(), 4);
        checkOutput("sofRes0", resAt(0), 17);
        checkOutput("sofRes1", resAt(1), 18);
        checkOutput("sofRes2", resAt(2), 117);
        checkOutput("sofRes3", resAt(3), 118);

        // Reset pulse in the middle of SEND discards the window.
        clearLogs();
        for (int k = 0; k < 11; k++)
            applyStimulus(8'(16*(k/4) + (k%4)), (k == 0));
        pixValid = 1'b0; sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midSendDsi", 32'(dsi), 1);
        nRst = 1'b0;
        #1;
        checkOutput("midRstDsi", 32'(dsi), 0);
        checkOutput("midRstResValid", 32'(resValid), 0);
        checkOutput("midRstReady", 32'(pixReady), 1);
        checkOutput("midRstMedNRst", 32'(medNRst), 0);
        @(posedge clk); #1;
        nRst = 1'b1;
        @(negedge clk);
        checkOutput("postRstReady", 32'(pixReady), 1);
        checkOutput("postRstDsi", 32'(dsi), 0);
        checkOutput("postRstMedNRst", 32'(medNRst), 1);
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++)
            applyStimulus(8'(200 + 16*(k/4) + (k%4)), 1'b0);
        pixValid = 1'b0;
        waitIdle("postRstIdle", 100);
        checkOutput("postRstResCount", resQ.size(), 2);
        checkOutput("postRstRes0", resAt(0), 217);
        checkOutput("postRstRes1", resAt(1), 218);
        checkOutput("errStillLow", 32'(err), 0);

`ifdef MEDFEED_WDOG_EN
        // MEDIAN never answers: 9 SEND + 255 WAIT + 1 CLR stall cycles.
        tieDsoLow = 1'b1;
        nRst = 1'b0;
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk); #1;
        clearLogs();
        for (int k = 0; k < 11; k++)
            applyStimulus(8'(16*(k/4) + (k%4)), (k == 0));
        pixValid = 1'b0;
        waitIdle("wdogIdle1", 400);
        checkOutput("wdogErr", 32'(err), 1);
        checkOutput("wdogNoRes", resQ.size(), 0);
        checkOutput("wdogStall0", stallAt(0), 265);
        checkOutput("wdogClr0", clrLow, 1);
        applyStimulus(8'd35, 1'b0);
        pixValid = 1'b0;
        waitIdle("wdogIdle2", 400);
        checkOutput("wdogErrSticky", 32'(err), 1);
        checkOutput("wdogNoRes2", resQ.size(), 0);
        checkOutput("wdogStall1", stallAt(1), 265);
        checkOutput("wdogClr1", clrLow, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
